conv_frame_sequencer: RTL
=========================

# conv_frame_sequencer

Controller that sequences one 2×2-kernel 2D convolution over an 8×8 signed 8-bit frame. It accepts a serial stream of 4 kernel weights followed by 64 pixels, buffers them, and time-shares a single multiply-accumulate unit across all 49 output positions. It returns the 7×7 results in row-major order over a valid/ready handshake and pulses `out_st` when the frame is complete. It sits between the frame source and the result consumer of the convolution processor.

## Interface
Parameters: none; all dimensions are fixed.

- Frame size: 8×8.
- Kernel size: 2×2.
- Output size: 7×7.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_st` in 1: start pulse; only honoured in IDLE.
- `din_valid` in 1: `din` carries a word this cycle.
- `din` in 8: signed weight or pixel word.
- `busy` out 1: high in every state except IDLE.
- `dout` out 18: signed convolution result.
- `dout_valid` out 1: `dout`, `dout_row` and `dout_col` are valid.
- `dout_ready` in 1: consumer accepts the result.
- `dout_row` out 3: output row index, 0..6.
- `dout_col` out 3: output column index, 0..6.
- `out_st` out 1: one-cycle pulse after the 49th result is accepted.

## Operation
- States: IDLE, LOAD_W, LOAD_PIX, COMPUTE, OUTPUT, DONE.
- **IDLE:** `in_st`=1 moves to LOAD_W and clears the word counter.
- **LOAD_W:** each cycle with `din_valid`=1 stores one weight, in the order w00, w01, w10, w11. After the 4th weight, move to LOAD_PIX.
- **LOAD_PIX:** each cycle with `din_valid`=1 stores pixel p[r][c] in row-major order (r=0..7, c=0..7). After the 64th pixel, move to COMPUTE with (row, col) = (0, 0).
- **COMPUTE:** 4 cycles, one product per cycle, in tap order w00·p[r][c], w01·p[r][c+1], w10·p[r+1][c], w11·p[r+1][c+1].
  - The accumulator is cleared in the first tap cycle.
  - After the 4th tap, move to OUTPUT.
- **OUTPUT:** `dout_valid`=1; `dout`, `dout_row` and `dout_col` are held stable until `dout_ready`=1.
  - On handshake with col<6: col+1, go to COMPUTE.
  - On handshake with col=6 and row<6: row+1, col=0, go to COMPUTE.
  - On handshake at (6, 6): go to DONE.
- **DONE:** `out_st`=1 for exactly one cycle, then IDLE.
- **Arithmetic:**
  - Each product is signed 8×8 → 16 bits, sign-extended to 18 bits.
  - The sum of 4 products is 18 bits signed; no saturation or truncation is needed.
  - Range is -65024..65536: max 4·(-128)·(-128) = 65536; min 4·(-128)·127 = -65024.
- **Ignored inputs:**
  - `din_valid` outside LOAD_W/LOAD_PIX.
  - `din_valid`=0 cycles: the counter holds, so gaps in the stream are allowed.
  - `in_st` outside IDLE.
  - `dout_ready` outside OUTPUT.
- Weights and pixel buffer are overwritten by each new frame and are not cleared by `reset`.

## Timing
- Reset values: state IDLE; `busy`=0, `dout`=0, `dout_valid`=0, `dout_row`=0, `dout_col`=0, `out_st`=0; counters and accumulator 0.
- `reset` mid-operation returns to IDLE on the next edge, drops `dout_valid`, and abandons the frame; no `out_st` is issued.
- `busy` rises in the cycle after `in_st` is sampled in IDLE.
- The first `dout_valid` rises 4 cycles after entering COMPUTE for (0, 0).
- With a continuous `din_valid` stream, this gives 1 (start) + 4 + 64 + 4 = 73 cycles from the `in_st` edge.
- Results cost 5 cycles each when `dout_ready` is held at 1: 4 COMPUTE cycles plus 1 OUTPUT cycle.
- A frame with no stalls takes 73 + 49·5 − 4 = 314 cycles from `in_st` to the final handshake.
- `out_st` is asserted in the cycle after the last handshake. `busy` drops the cycle after that.
- A new `in_st` is accepted the cycle after DONE.
- `dout_valid` and `dout` are registered outputs; there is no combinational path from `dout_ready` to `dout_valid`.

## Test plan
- **All ones:** all weights 1, all pixels 1, `dout_ready`=1 → 49 results, each `dout`=4, indices (0,0)…(6,6) in row-major order; `out_st` pulses exactly once, 1 cycle after the 49th handshake.
- **Identity tap:** weights (1,0,0,0), pixels p[r][c]=8r+c → `dout`(r,c) = 8r+c, e.g. (6,6)=54. Weights (0,0,0,1) → `dout`(r,c) = 8r+c+9.
- **Extremes:** all weights and pixels -128 → every `dout` = 65536. Weights 127 with pixels -128 → every `dout` = -65024.
- **Backpressure and gaps:**
  - Hold `dout_ready`=0 for 10 cycles at result (3,2): `dout_valid` stays 1 and `dout`/indices stay constant; the result is accepted once on release.
  - Random `din_valid` gaps give results identical to the continuous stream.
- **Protocol robustness:**
  - `in_st` pulses during LOAD_PIX and during OUTPUT are ignored, with frame results unchanged.
  - `din_valid` words sent in IDLE are not stored.
- **Reset mid-frame:** assert `reset` during COMPUTE of result (2,4) → next cycle all outputs are at reset values and no `out_st` occurs. A fresh frame then completes correctly with 49 results.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Sequencer for a 2x2-kernel convolution over an 8x8 signed frame.
// Buffers weights and pixels, then shares one MAC across all 49 output positions.
module conv_frame_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_st,
   input  logic        din_valid,
   input  logic [7:0]  din,
   output logic        busy,
   output logic [17:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [2:0]  dout_row,
   output logic [2:0]  dout_col,
   output logic        out_st
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_W   = 3'd1;
   localparam logic [2:0] S_LOAD_PIX = 3'd2;
   localparam logic [2:0] S_COMPUTE  = 3'd3;
   localparam logic [2:0] S_OUTPUT   = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [6:0]         cnt_q, cnt_d;
   logic [2:0]         row_q, row_d;
   logic [2:0]         col_q, col_d;
   logic [1:0]         tap_q, tap_d;
   logic signed [17:0] acc_q, acc_d;
   logic [17:0]        dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic signed [7:0]  w_q [4];
   logic signed [7:0]  w_d [4];
   logic signed [7:0]  pix_q [64];
   logic signed [7:0]  pix_d [64];

   logic [5:0]         base_idx, pix_idx;
   logic signed [7:0]  w_sel, p_sel;
   logic signed [15:0] prod;
   logic signed [17:0] prod_ext, sum;

   // {row, col} is row*8+col; the taps step right by 1 and down by 8.
   always_comb begin
      base_idx = {row_q, col_q};
      case (tap_q)
         2'd0:    pix_idx = base_idx;
         2'd1:    pix_idx = base_idx + 6'd1;
         2'd2:    pix_idx = base_idx + 6'd8;
         default: pix_idx = base_idx + 6'd9;
      endcase
      w_sel    = w_q[tap_q];
      p_sel    = pix_q[pix_idx];
      prod     = w_sel * p_sel;
      prod_ext = {{2{prod[15]}}, prod};
      sum      = ((tap_q == 2'd0) ? 18'sd0 : acc_q) + prod_ext;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      row_d        = row_q;
      col_d        = col_q;
      tap_d        = tap_q;
      acc_d        = acc_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      w_d          = w_q;
      pix_d        = pix_q;
      case (state_q)
         S_IDLE: begin
            if (in_st) begin
               state_d = S_LOAD_W;
               cnt_d   = 7'd0;
               row_d   = 3'd0;
               col_d   = 3'd0;
            end
         end
         S_LOAD_W: begin
            if (din_valid) begin
               w_d[cnt_q[1:0]] = din;
               if (cnt_q == 7'd3) begin
                  cnt_d   = 7'd0;
                  state_d = S_LOAD_PIX;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_LOAD_PIX: begin
            if (din_valid) begin
               pix_d[cnt_q[5:0]] = din;
               if (cnt_q == 7'd63) begin
                  cnt_d   = 7'd0;
                  row_d   = 3'd0;
                  col_d   = 3'd0;
                  tap_d   = 2'd0;
                  state_d = S_COMPUTE;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_COMPUTE: begin
            acc_d = sum;
            tap_d = tap_q + 2'd1;
            if (tap_q == 2'd3) begin
               dout_d       = sum;
               dout_valid_d = 1'b1;
               state_d      = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
               tap_d        = 2'd0;
               if (col_q != 3'd6) begin
                  col_d   = col_q + 3'd1;
                  state_d = S_COMPUTE;
               end else if (row_q != 3'd6) begin
                  row_d   = row_q + 3'd1;
                  col_d   = 3'd0;
                  state_d = S_COMPUTE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 7'd0;
         row_q        <= 3'd0;
         col_q        <= 3'd0;
         tap_q        <= 2'd0;
         acc_q        <= 18'sd0;
         dout_q       <= 18'd0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         tap_q        <= tap_d;
         acc_q        <= acc_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Frame storage survives reset; every new frame overwrites it completely.
   always_ff @(posedge clk) begin
      w_q   <= w_d;
      pix_q <= pix_d;
   end

   assign busy       = (state_q != S_IDLE);
   assign out_st     = (state_q == S_DONE);
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_row   = row_q;
   assign dout_col   = col_q;

endmodule
